// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-requester APB master arbiter.
package apb_arb_pkg;

  // Transfer sequencing states of the APB master
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // Requester identifiers, also used as the round-robin "last granted" value
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Watchdog counter width; a disabled watchdog (t == 0) still needs a 1-bit vector
  function automatic int unsigned wdog_width(input int unsigned t);
    return (t == 0) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/apb_rr_pick2.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the one not granted last.
module apb_rr_pick2
  import apb_arb_pkg::*;
(
  input  logic [1:0] valid_i,
  input  logic       last_i,
  input  logic       enable_i,
  output logic [1:0] grant_o
);

  // One-hot grant, all zero when the picker is disabled or nobody requests
  always_comb begin
    grant_o = 2'b00;
    if (enable_i) begin
      case (valid_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = (last_i == M0) ? 2'b10 : 2'b01;
        default: grant_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between two request/response requesters with
// round-robin arbitration, SETUP/ACCESS sequencing and an ACCESS-phase watchdog.
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  // requester 0
  input  logic              m0_valid,
  output logic              m0_ready,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_rsp_valid,
  output logic [DATA_W-1:0] m0_rsp_rdata,
  output logic              m0_rsp_err,
  // requester 1
  input  logic              m1_valid,
  output logic              m1_ready,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_rsp_valid,
  output logic [DATA_W-1:0] m1_rsp_rdata,
  output logic              m1_rsp_err,
  // APB master port
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr,
  // watchdog abort pulse
  output logic              timeout_o
);

  localparam int unsigned WD_W    = wdog_width(TIMEOUT);
  // Stall cycles already counted when the abort cycle arrives
  localparam int unsigned WD_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  state_e            state_q,     state_d;
  logic              owner_q,     owner_d;
  logic              last_q,      last_d;
  logic [ADDR_W-1:0] paddr_q,     paddr_d;
  logic              pwrite_q,    pwrite_d;
  logic [DATA_W-1:0] pwdata_q,    pwdata_d;
  logic [WD_W-1:0]   wdog_q,      wdog_d;
  logic [1:0]        rsp_vld_q,   rsp_vld_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q,   rsp_err_d;
  logic              tmo_q,       tmo_d;

  logic [1:0]        grant;
  logic              win_id;
  logic              pick_en;

  // Arbitration only happens in IDLE and never while reset is asserted,
  // so ready stays low during reset
  assign pick_en = (state_q == IDLE) && reset_n;

  apb_rr_pick2 u_pick (
    .valid_i  ({m1_valid, m0_valid}),
    .last_i   (last_q),
    .enable_i (pick_en),
    .grant_o  (grant)
  );

  assign win_id = grant[1];

  // Next-state logic for the transfer FSM, capture registers, watchdog and response
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    wdog_d      = wdog_q;
    rsp_vld_d   = 2'b00;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    tmo_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          owner_d  = win_id;
          last_d   = win_id;
          paddr_d  = (win_id == M1) ? m1_addr  : m0_addr;
          pwrite_d = (win_id == M1) ? m1_write : m0_write;
          pwdata_d = (win_id == M1) ? m1_wdata : m0_wdata;
          state_d  = SETUP;
        end
      end

      SETUP: begin
        wdog_d  = '0;
        state_d = ACCESS;
      end

      ACCESS: begin
        if (pready) begin
          // Completion takes priority over a watchdog expiring in the same cycle
          state_d            = IDLE;
          rsp_vld_d[owner_q] = 1'b1;
          rsp_err_d          = pslverr;
          rsp_rdata_d        = (pwrite_q || pslverr) ? '0 : prdata;
        end else if ((TIMEOUT != 0) && (wdog_q == WD_W'(WD_LAST))) begin
          state_d            = IDLE;
          rsp_vld_d[owner_q] = 1'b1;
          rsp_err_d          = 1'b1;
          rsp_rdata_d        = '0;
          tmo_d              = 1'b1;
        end else if (TIMEOUT != 0) begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset leaves the pointer favouring requester 0
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= M0;
      last_q      <= M1;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      wdog_q      <= '0;
      rsp_vld_q   <= 2'b00;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      wdog_q      <= wdog_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign m0_ready = grant[0];
  assign m1_ready = grant[1];

  assign psel    = (state_q != IDLE);
  assign penable = (state_q == ACCESS);
  assign paddr   = paddr_q;
  assign pwrite  = pwrite_q;
  assign pwdata  = pwdata_q;

  // Response fields are only visible to the requester whose pulse is active
  assign m0_rsp_valid = rsp_vld_q[0];
  assign m0_rsp_rdata = rsp_vld_q[0] ? rsp_rdata_q : '0;
  assign m0_rsp_err   = rsp_vld_q[0] & rsp_err_q;
  assign m1_rsp_valid = rsp_vld_q[1];
  assign m1_rsp_rdata = rsp_vld_q[1] ? rsp_rdata_q : '0;
  assign m1_rsp_err   = rsp_vld_q[1] & rsp_err_q;

  assign timeout_o = tmo_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed scoreboard bench for apb_master_arbiter (watchdog limit 4, plus a disabled-watchdog instance).
module tb_apb_master_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // ---------------- DUT A: TIMEOUT = 4 ----------------
  logic        m0_valid = 0, m1_valid = 0, m0_write = 0, m1_write = 0;
  logic [31:0] m0_addr = 0, m1_addr = 0, m0_wdata = 0, m1_wdata = 0;
  logic        m0_ready, m1_ready, m0_rsp_valid, m1_rsp_valid, m0_rsp_err, m1_rsp_err;
  logic [31:0] m0_rsp_rdata, m1_rsp_rdata;
  logic [31:0] paddr, pwdata;
  logic        pwrite, psel, penable, timeout_o;
  logic [31:0] prdata_v = 0;
  logic        slverr_v = 0;
  logic        pready = 0;

  apb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_write(m0_write),
    .m0_wdata(m0_wdata), .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
    .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_write(m1_write),
    .m1_wdata(m1_wdata), .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
    .prdata(prdata_v), .pready(pready), .pslverr(slverr_v), .timeout_o(timeout_o)
  );

  // APB slave model: pready rises on ACCESS cycle number ws_cfg (0-based); -1 never
  int ws_cfg = 0;
  int acc_cnt = 0;
  always @(negedge clk) begin
    if (psel && penable) begin
      pready = (acc_cnt == ws_cfg);
      acc_cnt++;
    end else begin
      pready = 1'b0;
      acc_cnt = 0;
    end
  end

  // ---------------- DUT B: TIMEOUT = 0 (watchdog disabled) ----------------
  logic        b_m0_valid = 0, b_pready = 0;
  logic [31:0] b_m0_addr = 0, b_prdata = 0;
  logic        b_m0_ready, b_m1_ready, b_m0_rsp_valid, b_m1_rsp_valid, b_m0_rsp_err, b_m1_rsp_err;
  logic [31:0] b_m0_rsp_rdata, b_m1_rsp_rdata, b_paddr, b_pwdata;
  logic        b_pwrite, b_psel, b_penable, b_timeout;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = 32'h0;

  apb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(0)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .m0_valid(b_m0_valid), .m0_ready(b_m0_ready), .m0_addr(b_m0_addr), .m0_write(zero1),
    .m0_wdata(zero32), .m0_rsp_valid(b_m0_rsp_valid), .m0_rsp_rdata(b_m0_rsp_rdata), .m0_rsp_err(b_m0_rsp_err),
    .m1_valid(zero1), .m1_ready(b_m1_ready), .m1_addr(zero32), .m1_write(zero1),
    .m1_wdata(zero32), .m1_rsp_valid(b_m1_rsp_valid), .m1_rsp_rdata(b_m1_rsp_rdata), .m1_rsp_err(b_m1_rsp_err),
    .paddr(b_paddr), .pwrite(b_pwrite), .psel(b_psel), .penable(b_penable), .pwdata(b_pwdata),
    .prdata(b_prdata), .pready(b_pready), .pslverr(zero1), .timeout_o(b_timeout)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        id;
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic mon_id;

  always @(negedge clk) begin
    if (reset_n) begin
      if (m0_rsp_valid || m1_rsp_valid) begin
        chk("rsp_single_owner", {63'd0, m0_rsp_valid & m1_rsp_valid}, 64'd0);
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rsp_unexpected: got response m0=%0b m1=%0b, expected none (cycle %0d)",
                   m0_rsp_valid, m1_rsp_valid, cyc);
        end else begin
          mon_e  = sb.pop_front();
          mon_id = m1_rsp_valid;
          chk("rsp_id",    {63'd0, mon_id}, {63'd0, mon_e.id});
          chk("rsp_rdata", mon_id ? m1_rsp_rdata : m0_rsp_rdata, mon_e.rdata);
          chk("rsp_err",   {63'd0, mon_id ? m1_rsp_err : m0_rsp_err}, {63'd0, mon_e.err});
          chk("rsp_timeout_o", {63'd0, timeout_o}, {63'd0, mon_e.tmo});
          chk("rsp_cycle", cyc, mon_e.cyc);
        end
      end else if (timeout_o) begin
        n_chk++;
        n_fail++;
        $display("FAIL tmo_orphan: got timeout_o=1 without response, expected 0 (cycle %0d)", cyc);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input logic id, input logic v, input logic [31:0] a,
                         input logic w, input logic [31:0] d);
    if (id) begin
      m1_valid = v; m1_addr = a; m1_write = w; m1_wdata = d;
    end else begin
      m0_valid = v; m0_addr = a; m0_write = w; m0_wdata = d;
    end
  endtask

  // Issue one transfer, check SETUP/ACCESS phases; optionally push the expected response.
  // Returns at the negedge of the first ACCESS cycle.
  task automatic issue(input logic id, input logic [31:0] a, input logic w, input logic [31:0] d,
                       input int ws, input logic [31:0] rd, input logic se, input bit push,
                       input logic [31:0] exp_rd, input logic exp_err, input logic exp_tmo,
                       input int lat);
    int acc;
    exp_t e;
    ws_cfg = ws; prdata_v = rd; slverr_v = se;
    @(posedge clk); #1;
    set_req(id, 1'b1, a, w, d);
    acc = -1;
    for (int i = 0; i < 10 && acc < 0; i++) begin
      @(negedge clk);
      if (id ? m1_ready : m0_ready) begin
        acc = cyc;
        if (push) begin
          e.id = id; e.rdata = exp_rd; e.err = exp_err; e.tmo = exp_tmo; e.cyc = acc + lat;
          sb.push_back(e);
        end
      end
      @(posedge clk); #1;
      if (acc >= 0) set_req(id, 1'b0, a, w, d);
    end
    chk("accept", {63'd0, acc >= 0}, 64'd1);
    @(negedge clk);
    chk("setup_psel",    {62'd0, psel, penable}, 64'd2);
    chk("setup_paddr",   paddr, a);
    chk("setup_pwrite",  {63'd0, pwrite}, {63'd0, w});
    if (w) chk("setup_pwdata", pwdata, d);
    @(negedge clk);
    chk("access_psel",   {62'd0, psel, penable}, 64'd3);
  endtask

  // ---------------- main sequence ----------------
  int n, prev, pen, bad;

  initial begin
    // reset state; a request during reset must not be acknowledged
    m0_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_psel_penable", {62'd0, psel, penable}, 64'd0);
    chk("rst_paddr",  paddr, 32'h0);
    chk("rst_pwdata", pwdata, 32'h0);
    chk("rst_rsp",    {60'd0, m0_rsp_valid, m1_rsp_valid, timeout_o, pwrite}, 64'd0);
    chk("rst_ready",  {62'd0, m0_ready, m1_ready}, 64'd0);
    m0_valid = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;

    // both requesters contend for 8 transfers: strict alternation from m0, 3-cycle spacing
    ws_cfg = 0; slverr_v = 0;
    @(posedge clk); #1;
    set_req(1'b0, 1'b1, 32'hF000_0010, 1'b0, 32'h0);
    set_req(1'b1, 1'b1, 32'hF000_0020, 1'b0, 32'h0);
    n = 0; prev = 0;
    for (int i = 0; i < 40 && n < 8; i++) begin
      @(negedge clk);
      if (m0_ready || m1_ready) begin
        exp_t e;
        chk("rr_one_ready", {63'd0, m0_ready & m1_ready}, 64'd0);
        chk("rr_grant", {63'd0, m1_ready}, n % 2);
        if (n > 0) chk("rr_gap", cyc - prev, 3);
        prdata_v = 32'h1000 + n;
        e.id = m1_ready; e.rdata = 32'h1000 + n; e.err = 0; e.tmo = 0; e.cyc = cyc + 3;
        sb.push_back(e);
        prev = cyc;
        n++;
      end
      @(posedge clk); #1;
      if (n == 8) begin
        m0_valid = 1'b0;
        m1_valid = 1'b0;
      end
    end
    chk("rr_count", n, 8);
    repeat (4) @(negedge clk);

    // single m0 read, zero wait states
    issue(1'b0, 32'hF000_0004, 1'b0, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 1'b1,
          32'hDEAD_BEEF, 1'b0, 1'b0, 3);
    @(negedge clk);
    chk("read_done_psel", {63'd0, psel}, 64'd0);

    // m1 write, two wait states, slave error
    issue(1'b1, 32'hF100_0000, 1'b1, 32'h0000_005A, 2, 32'h1234_5678, 1'b1, 1'b1,
          32'h0, 1'b1, 1'b0, 5);
    pen = 1;
    repeat (4) begin
      @(negedge clk);
      if (penable) pen++;
    end
    chk("write_penable_cycles", pen, 3);
    slverr_v = 1'b0;

    // watchdog abort after 4 stalled ACCESS cycles
    issue(1'b0, 32'hF000_0100, 1'b0, 32'h0, -1, 32'hAAAA_5555, 1'b0, 1'b1,
          32'h0, 1'b1, 1'b1, 6);
    repeat (3) @(negedge clk);
    chk("tmo_psel_before", {63'd0, psel}, 64'd1);
    @(negedge clk);
    chk("tmo_psel_after", {63'd0, psel}, 64'd0);
    repeat (2) @(negedge clk);

    // pready on the limit cycle completes normally
    issue(1'b0, 32'hF000_0104, 1'b0, 32'h0, 3, 32'h0BAD_F00D, 1'b0, 1'b1,
          32'h0BAD_F00D, 1'b0, 1'b0, 6);
    repeat (5) @(negedge clk);

    // reset during ACCESS: bus drops, no response, then m0 wins a tie
    issue(1'b0, 32'hF000_0200, 1'b0, 32'h0, -1, 32'h0, 1'b0, 1'b0,
          32'h0, 1'b0, 1'b0, 0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rstmid_bus", {62'd0, psel, penable}, 64'd0);
    chk("rstmid_rsp", {61'd0, m0_rsp_valid, m1_rsp_valid, timeout_o}, 64'd0);
    ws_cfg = 0; prdata_v = 32'h0000_0077;
    set_req(1'b0, 1'b1, 32'hF000_0300, 1'b0, 32'h0);
    set_req(1'b1, 1'b1, 32'hF000_0304, 1'b0, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rstmid_first_grant", {62'd0, m1_ready, m0_ready}, 64'd1);
    if (m0_ready) begin
      exp_t e;
      e.id = 1'b0; e.rdata = 32'h0000_0077; e.err = 0; e.tmo = 0; e.cyc = cyc + 3;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    repeat (4) @(negedge clk);

    // disabled watchdog: 1000 stalled cycles, then completion
    @(posedge clk); #1;
    b_m0_valid = 1'b1;
    b_m0_addr = 32'hF200_0008;
    @(negedge clk);
    chk("nowd_accept", {63'd0, b_m0_ready}, 64'd1);
    @(posedge clk); #1;
    b_m0_valid = 1'b0;
    chk("nowd_paddr", b_paddr, 32'hF200_0008);
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (!b_psel || b_m0_rsp_valid || b_timeout || b_m1_rsp_valid || b_m1_ready) bad++;
    end
    chk("nowd_no_abort", bad, 0);
    chk("nowd_still_access", {63'd0, b_penable}, 64'd1);
    @(posedge clk); #1;
    b_pready = 1'b1;
    b_prdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    b_pready = 1'b0;
    @(negedge clk);
    chk("nowd_rsp", {61'd0, b_m0_rsp_valid, b_m0_rsp_err, b_timeout}, 64'd4);
    chk("nowd_rdata", b_m0_rsp_rdata, 32'hCAFE_F00D);
    chk("nowd_idle", {60'd0, b_psel, b_pwrite, b_m1_rsp_err, |b_m1_rsp_rdata}, 64'd0);
    chk("nowd_pwdata", b_pwdata, 32'h0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
